// File: rtl/simon_pkg.sv
// Shared types and default timing for the colour-sequence player.
// Holds the colour code type, the player state enum and the default sizes.
package simon_pkg;

    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_ON_CYC  = 8;
    localparam int DEF_GAP_CYC = 4;

    typedef logic [1:0] color_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP,
        S_FIN
    } state_t;

    // One-hot LED drive for a colour code: code n lights led[n].
    function automatic logic [3:0] color_onehot(input color_t c);
        return 4'b0001 << c;
    endfunction

    // Counter width able to hold the larger of the two phase reload values.
    function automatic int timer_width(input int on_cyc, input int gap_cyc);
        int m;
        m = (on_cyc > gap_cyc) ? on_cyc : gap_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Down-counter shared by the ON and GAP phases: load, count while enabled,
// and flag expiry when the count reaches zero.
module step_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d is assigned a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loading N-1 makes a phase last exactly N cycles.
    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/seq_player.sv
// Plays a latched sequence of colour codes on a one-hot LED, each step lit
// for ON_CYC cycles then dark for GAP_CYC. Define SEQ_PAUSE_EN to add a pause input.
module seq_player
    import simon_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int ON_CYC  = DEF_ON_CYC,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*MAX_LEN-1:0] seq,
    input  logic [4:0]           len,
`ifdef SEQ_PAUSE_EN
    input  logic                 pause,
`endif
    output logic                 busy,
    output logic [3:0]           led,
    output logic [3:0]           step_idx,
    output logic                 done
);

    localparam int           TW       = timer_width(ON_CYC, GAP_CYC);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYC - 1);
    localparam logic [4:0]   MAX_LEN5 = 5'(MAX_LEN);

    state_t               state_q;
    logic [2*MAX_LEN-1:0] seq_q;
    logic [4:0]           len_q;
    logic [3:0]           step_q;
    logic [3:0]           led_q;
    logic                 busy_q;
    logic                 done_q;

    logic [4:0]    len_d;
    logic [3:0]    step_d;
    logic [3:0]    led_first_d;
    logic [3:0]    led_next_d;
    logic          last_step;
    logic          run;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;

`ifdef SEQ_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    step_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (run),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        len_d       = (len > MAX_LEN5) ? MAX_LEN5 : len;
        step_d      = step_q + 4'd1;
        last_step   = ({1'b0, step_q} == (len_q - 5'd1));
        led_first_d = color_onehot(color_t'(seq[1:0]));
        led_next_d  = color_onehot(color_t'(seq_q[{step_d, 1'b0} +: 2]));
        tmr_load    = 1'b0;
        tmr_val     = ON_LOAD;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = ON_LOAD;
                end
            end
            S_ON: begin
                if (run && tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (run && tmr_expired && !last_step) begin
                    tmr_load = 1'b1;
                    tmr_val  = ON_LOAD;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    // NOTE: the latched sequence is cleared on reset like every other
    // register so a reset leaves no trace of the previous playback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            step_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seq_q  <= seq;
                        len_q  <= len_d;
                        step_q <= '0;
                        busy_q <= 1'b1;
                        if (len_d == 5'd0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ON;
                            led_q   <= led_first_d;
                        end
                    end
                end
                S_ON: begin
                    if (run && tmr_expired) begin
                        state_q <= S_GAP;
                        led_q   <= '0;
                    end
                end
                S_GAP: begin
                    if (run && tmr_expired) begin
                        if (last_step) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ON;
                            step_q  <= step_d;
                            led_q   <= led_next_d;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign led      = led_q;
    assign step_idx = step_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player: a per-cycle expected trace is built from
// the step/phase rules and consumed one entry per clock (held while paused).
module tb_seq_player;

    localparam int MAXL = 16;
    localparam int ONC  = 8;
    localparam int GAPC = 4;
    localparam int PER  = ONC + GAPC;

    typedef struct packed {
        logic [3:0] led;
        logic [3:0] step;
        logic       busy;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] seq;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic [3:0]  led;
    logic [3:0]  step_idx;
`ifdef SEQ_PAUSE_EN
    logic        pause_drv;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_player #(
        .MAX_LEN (MAXL),
        .ON_CYC  (ONC),
        .GAP_CYC (GAPC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .seq      (seq),
        .len      (len),
`ifdef SEQ_PAUSE_EN
        .pause    (pause_drv),
`endif
        .busy     (busy),
        .led      (led),
        .step_idx (step_idx),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a playback and compare every cycle against the expected trace.
    // dist_at: cycle at which start is re-pulsed with altered seq/len.
    // pause_at/pause_n: cycles during which pause is held high.
    task automatic play(input logic [31:0] s, input logic [4:0] l, input int dist_at,
                        input int pause_at, input int pause_n, input string tag);
        exp_t       q[$];
        exp_t       e;
        int         n;
        int         t;
        int         done_cyc;
        int         exp_done;
        logic [1:0] code;
        logic       p;

        n = (int'(l) > MAXL) ? MAXL : int'(l);
        for (int k = 0; k < n; k++) begin
            code = s[2*k +: 2];
            for (int c = 0; c < ONC; c++)
                q.push_back('{led: 4'(1 << code), step: 4'(k), busy: 1'b1, done: 1'b0});
            for (int c = 0; c < GAPC; c++)
                q.push_back('{led: 4'd0, step: 4'(k), busy: 1'b1, done: 1'b0});
        end
        q.push_back('{led: 4'd0, step: 4'd0, busy: 1'b1, done: 1'b1});
        exp_done = n * PER + 1 + pause_n;

        @(negedge clk);
        seq   = s;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        t        = 1;
        done_cyc = -1;
        while (q.size() > 0) begin
            e = q[0];
            check($sformatf("%s.led@%0d", tag, t), 32'(led), 32'(e.led));
            check($sformatf("%s.busy@%0d", tag, t), 32'(busy), 32'(e.busy));
            check($sformatf("%s.done@%0d", tag, t), 32'(done), 32'(e.done));
            if (!e.done)
                check($sformatf("%s.step@%0d", tag, t), 32'(step_idx), 32'(e.step));
            if (done === 1'b1 && done_cyc < 0)
                done_cyc = t;
            if (t == dist_at) begin
                start = 1'b1;
                seq   = ~s;
                len   = 5'($urandom_range(0, 31));
            end else begin
                start = 1'b0;
            end
            p = (t >= pause_at) && (t < pause_at + pause_n);
`ifdef SEQ_PAUSE_EN
            pause_drv = p;
`endif
            if (!(p && !e.done))
                void'(q.pop_front());
            @(negedge clk);
            t++;
        end
        start = 1'b0;
`ifdef SEQ_PAUSE_EN
        pause_drv = 1'b0;
`endif
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        check({tag, ".idle_led"}, 32'(led), 32'd0);
        check({tag, ".done_cycle"}, done_cyc, exp_done);
    endtask

    initial begin
        logic [31:0] rs;

        // Reset state; start held during reset must be lost.
        reset = 1'b1;
        start = 1'b1;
        seq   = 32'h0000_00E4;
        len   = 5'd3;
`ifdef SEQ_PAUSE_EN
        pause_drv = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst.led", 32'(led), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.step", 32'(step_idx), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst.start_lost", 32'(busy), 32'd0);
        end

        // Four colours in order, done at cycle 49.
        play(32'h0000_00E4, 5'd4, -1, -1, 0, "basic");
        // Zero-length sequence.
        play($urandom, 5'd0, -1, -1, 0, "len0");
        // Oversized length clamps to MAX_LEN.
        play($urandom, 5'd20, -1, -1, 0, "clamp");
        // Restart attempt and input changes mid-playback are ignored.
        play($urandom, 5'd6, 30, -1, 0, "disturb");
        // Random sequences and lengths.
        for (int i = 0; i < 3; i++)
            play($urandom, 5'($urandom_range(1, MAXL)), -1, -1, 0, $sformatf("rand%0d", i));

        // Reset during step 2 aborts playback immediately.
        @(negedge clk);
        seq   = 32'h0000_00E4;
        len   = 5'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * PER + 3) @(negedge clk);
        check("abort.pre_step", 32'(step_idx), 32'd2);
        check("abort.pre_led", 32'(led), 32'h4);
        #2 reset = 1'b1;
        #1;
        check("abort.led", 32'(led), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.step", 32'(step_idx), 32'd0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            check($sformatf("abort.no_done@%0d", i), 32'(done), 32'd0);
            check($sformatf("abort.idle@%0d", i), 32'(busy), 32'd0);
        end
        rs = $urandom;
        play(rs, 5'd3, -1, -1, 0, "after_abort");

`ifdef SEQ_PAUSE_EN
        // Pause held five cycles during the ON phase of step 1.
        play(32'h0000_00E4, 5'd4, -1, 14, 5, "pause");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
